crossing_scheduler: RTL and testbench

Phase sequencer for the two-way pedestrian-crossing light. Latches raw crossing requests `Sa`/`Sb`, arbitrates them round-robin, and drives the road lamps (`Ra/Ya/Ga`, `Rb/Yb/Gb`) and per-crossing walk lamps through timed GO → STOP → WALK → CLEAR phases. It enforces minimum green and fixed yellow/walk/clearance durations, so no crossing is served instantly or starves.

---
 rtl/crossing_pkg.sv | 54 +++++
 rtl/crossing_scheduler_if.sv | 26 ++
 rtl/phase_timer.sv | 23 ++
 rtl/crossing_scheduler.sv | 99 +++++++++
 tb/tb_crossing_scheduler.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/crossing_pkg.sv
// Shared types, default phase durations and helpers for the pedestrian-crossing
// sequencer.
package crossing_pkg;

    typedef enum logic [1:0] {GO, STOP, WALK, CLEAR} state_t;
    typedef enum logic {XING_A, XING_B} xing_t;

    localparam int DEF_GREEN_MIN = 8;
    localparam int DEF_YELLOW_T  = 3;
    localparam int DEF_WALK_T    = 6;
    localparam int DEF_CLEAR_T   = 2;

    typedef struct packed {
        logic ra;
        logic ya;
        logic ga;
        logic rb;
        logic yb;
        logic gb;
        logic walk_a;
        logic walk_b;
        logic busy;
    } lamps_t;

    // One spare bit keeps a count of exactly 2**k representable.
    function automatic int TMR_W(int g, int y, int w, int c);
        int m;
        m = g;
        if (y > m) m = y;
        if (w > m) m = w;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

    // Road B stays red in every phase; only road A and the walk lamps cycle.
    function automatic lamps_t decode_lamps(state_t s, xing_t x);
        lamps_t l;
        l      = '0;
        l.rb   = 1'b1;
        l.busy = (s != GO);
        case (s)
            GO:    l.ga = 1'b1;
            STOP:  l.ya = 1'b1;
            WALK: begin
                l.ra     = 1'b1;
                l.walk_a = (x == XING_A);
                l.walk_b = (x == XING_B);
            end
            CLEAR: l.ra = 1'b1;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/crossing_scheduler_if.sv
// Request inputs and lamp outputs of the crossing sequencer.
interface crossing_scheduler_if;

    logic Sa;
    logic Sb;
    logic Ra;
    logic Ya;
    logic Ga;
    logic Rb;
    logic Yb;
    logic Gb;
    logic walk_a;
    logic walk_b;
    logic busy;

    modport master (
        output Sa, Sb,
        input  Ra, Ya, Ga, Rb, Yb, Gb, walk_a, walk_b, busy
    );

    modport slave (
        input  Sa, Sb,
        output Ra, Ya, Ga, Rb, Yb, Gb, walk_a, walk_b, busy
    );

endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter that saturates at zero; done flags the final cycle of
// a phase.
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/crossing_scheduler.sv
// Phase sequencer for the two-way pedestrian crossing: request latches,
// round-robin arbiter, GO/STOP/WALK/CLEAR FSM and registered lamp decode.
module crossing_scheduler
    import crossing_pkg::*;
#(
    parameter int GREEN_MIN = DEF_GREEN_MIN,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int WALK_T    = DEF_WALK_T,
    parameter int CLEAR_T   = DEF_CLEAR_T
) (
    input  logic           clk,
    input  logic           rst,
    crossing_scheduler_if.slave xif
);

    localparam int TW = TMR_W(GREEN_MIN, YELLOW_T, WALK_T, CLEAR_T);

    state_t        state, nxt_state;
    xing_t         served, nxt_served, last_served, pick;
    logic          pend_a, pend_b;
    logic          advance, enter_walk, done;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    lamps_t        lamps;

    // On a tie, serve the crossing that did not walk last.
    assign pick = (pend_a && pend_b) ? ((last_served == XING_B) ? XING_A : XING_B)
                                     : (pend_a ? XING_A : XING_B);

    always_comb begin
        advance    = 1'b0;
        nxt_state  = state;
        nxt_served = served;
        case (state)
            GO: if (done && (pend_a || pend_b)) begin
                advance    = 1'b1;
                nxt_state  = STOP;
                nxt_served = pick;
            end
            STOP:  if (done) begin advance = 1'b1; nxt_state = WALK;  end
            WALK:  if (done) begin advance = 1'b1; nxt_state = CLEAR; end
            CLEAR: if (done) begin advance = 1'b1; nxt_state = GO;    end
        endcase
    end

    // The timer is reloaded with N-1 on the edge that enters each phase.
    always_comb begin
        tmr_load = rst | advance;
        tmr_val  = TW'(GREEN_MIN - 1);
        if (!rst) begin
            case (nxt_state)
                GO:    tmr_val = TW'(GREEN_MIN - 1);
                STOP:  tmr_val = TW'(YELLOW_T - 1);
                WALK:  tmr_val = TW'(WALK_T - 1);
                CLEAR: tmr_val = TW'(CLEAR_T - 1);
            endcase
        end
    end

    assign enter_walk = advance && (state == STOP);

    phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (done)
    );

    // A request present on the WALK-entry edge re-arms its latch immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= GO;
            served      <= XING_A;
            last_served <= XING_B;
            pend_a      <= 1'b0;
            pend_b      <= 1'b0;
            lamps       <= decode_lamps(GO, XING_A);
        end else begin
            state  <= nxt_state;
            served <= nxt_served;
            lamps  <= decode_lamps(nxt_state, nxt_served);
            if (enter_walk)
                last_served <= served;
            pend_a <= xif.Sa | (pend_a & ~(enter_walk && (served == XING_A)));
            pend_b <= xif.Sb | (pend_b & ~(enter_walk && (served == XING_B)));
        end
    end

    assign xif.Ra     = lamps.ra;
    assign xif.Ya     = lamps.ya;
    assign xif.Ga     = lamps.ga;
    assign xif.Rb     = lamps.rb;
    assign xif.Yb     = lamps.yb;
    assign xif.Gb     = lamps.gb;
    assign xif.walk_a = lamps.walk_a;
    assign xif.walk_b = lamps.walk_b;
    assign xif.busy   = lamps.busy;

endmodule

// File: tb/tb_crossing_scheduler.sv
// Directed bench for crossing_scheduler: lamp vectors are checked at every
// negedge against hand-derived phase sequences using default durations.
module tb_crossing_scheduler;

    // Lamp vector order: {Ra, Ya, Ga, Rb, Yb, Gb, walk_a, walk_b, busy}
    localparam logic [8:0] P_GO    = 9'b001_100_00_0;
    localparam logic [8:0] P_STOP  = 9'b010_100_00_1;
    localparam logic [8:0] P_WALKA = 9'b100_100_10_1;
    localparam logic [8:0] P_WALKB = 9'b100_100_01_1;
    localparam logic [8:0] P_CLEAR = 9'b100_100_00_1;

    logic clk;
    logic rst;
    int   testsRun;
    int   failCount;

    crossing_scheduler_if xif ();

    crossing_scheduler dut (
        .clk (clk),
        .rst (rst),
        .xif (xif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic sa, input logic sb);
        xif.Sa = sa;
        xif.Sb = sb;
    endtask

    task automatic checkOutput(input logic [8:0] expected, input string tag);
        logic [8:0] observed;
        observed = {xif.Ra, xif.Ya, xif.Ga, xif.Rb, xif.Yb, xif.Gb,
                    xif.walk_a, xif.walk_b, xif.busy};
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Check the current negedge sample, then advance one cycle; n times.
    task automatic expectRun(input logic [8:0] expected, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            checkOutput(expected, tag);
            @(negedge clk);
        end
    endtask

    // Leaves the bench at the negedge right after the reset edge.
    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;
        rst       = 1'b1;
        applyStimulus(1'b0, 1'b0);

        // Idle after reset
        doReset();
        expectRun(P_GO, 20, "idle_go");

        // Sa one-cycle pulse two cycles after reset
        doReset();
        expectRun(P_GO, 2, "pulse_go_pre");
        applyStimulus(1'b1, 1'b0);
        expectRun(P_GO, 1, "pulse_go_sa");
        applyStimulus(1'b0, 1'b0);
        expectRun(P_GO, 5, "pulse_go_min");
        expectRun(P_STOP, 3, "pulse_stop");
        expectRun(P_WALKA, 6, "pulse_walk_a");
        expectRun(P_CLEAR, 2, "pulse_clear");
        expectRun(P_GO, 1, "pulse_back_go");

        // Simultaneous requests: A first, then B, then A again on the next tie
        doReset();
        expectRun(P_GO, 8, "tie1_go_min");
        applyStimulus(1'b1, 1'b1);
        expectRun(P_GO, 1, "tie1_go_req");
        applyStimulus(1'b0, 1'b0);
        expectRun(P_GO, 1, "tie1_go_latch");
        expectRun(P_STOP, 3, "tie1_stop_a");
        expectRun(P_WALKA, 6, "tie1_walk_a");
        expectRun(P_CLEAR, 2, "tie1_clear_a");
        expectRun(P_GO, 8, "tie1_go_between");
        expectRun(P_STOP, 3, "tie1_stop_b");
        expectRun(P_WALKB, 6, "tie1_walk_b");
        expectRun(P_CLEAR, 2, "tie1_clear_b");
        expectRun(P_GO, 8, "tie2_go_min");
        applyStimulus(1'b1, 1'b1);
        expectRun(P_GO, 1, "tie2_go_req");
        applyStimulus(1'b0, 1'b0);
        expectRun(P_GO, 1, "tie2_go_latch");
        expectRun(P_STOP, 3, "tie2_stop_a");
        expectRun(P_WALKA, 3, "tie2_walk_a");

        // Reset mid-WALK with B still pending: must drop back to idle GO
        doReset();
        expectRun(P_GO, 20, "rst_mid_walk_go");

        // Sa held through a whole A service: a second A service follows
        applyStimulus(1'b1, 1'b0);
        expectRun(P_GO, 2, "hold_go");
        expectRun(P_STOP, 3, "hold_stop1");
        expectRun(P_WALKA, 6, "hold_walk1");
        applyStimulus(1'b0, 1'b0);
        expectRun(P_CLEAR, 2, "hold_clear1");
        expectRun(P_GO, 8, "hold_go_min");
        expectRun(P_STOP, 3, "hold_stop2");
        expectRun(P_WALKA, 6, "hold_walk2");
        expectRun(P_CLEAR, 2, "hold_clear2");
        expectRun(P_GO, 12, "hold_idle");

        // Sb pulse during the STOP of an A service is kept and served next
        applyStimulus(1'b1, 1'b0);
        expectRun(P_GO, 1, "late_go_req");
        applyStimulus(1'b0, 1'b0);
        expectRun(P_GO, 1, "late_go_latch");
        expectRun(P_STOP, 1, "late_stop_a0");
        applyStimulus(1'b0, 1'b1);
        expectRun(P_STOP, 1, "late_stop_a1");
        applyStimulus(1'b0, 1'b0);
        expectRun(P_STOP, 1, "late_stop_a2");
        expectRun(P_WALKA, 6, "late_walk_a");
        expectRun(P_CLEAR, 2, "late_clear_a");
        expectRun(P_GO, 8, "late_go_min");
        expectRun(P_STOP, 3, "late_stop_b");
        expectRun(P_WALKB, 6, "late_walk_b");
        expectRun(P_CLEAR, 2, "late_clear_b");
        expectRun(P_GO, 10, "late_idle");

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
